// File: rtl/mmio_hub.sv
`timescale 1ns/1ps
// mmio_hub
// Memory-mapped I/O hub between a datapath load/store port and data memory.
// Stores to a console channel data address are queued in that channel's FIFO
// and streamed out; stores to the test status address set sticky pass/fail
// flags. Every other access passes through to data memory.
//
// Optional feature (macro MMIO_HUB_STATUS_EN): loads from
// CONSOLE_BASE+16*n+4 return the free-entry count of channel n, and loads from
// TEST_STAT_ADDR+4 return {.., test_failed, test_passed}.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   io_addr/io_wdata         datapath address / store data
//   io_we/io_re              datapath store / load strobes
//   io_rdata                 load data back to the datapath
//   io_stall                 datapath must hold the current store
//   dmem_we/dmem_wdata       filtered store to data memory
//   dmem_rdata               data memory read data
//   con_valid/con_ready      per-channel output stream handshake
//   con_data                 channel n head entry in [n*XLEN +: XLEN]
//   test_passed/test_failed  sticky test result flags
//   fail_code                first non-magic value written to TEST_STAT_ADDR
//
// Handshake: a console beat transfers at a rising edge where con_valid[n] and
// con_ready[n] are both high; con_valid never depends on con_ready, and the
// head entry stays stable on con_data while con_valid is high and not taken.
module mmio_hub #(
  parameter int               XLEN           = 32,
  parameter int               NCHAN          = 2,
  parameter int               FIFO_DEPTH     = 8,
  parameter logic [XLEN-1:0]  CONSOLE_BASE   = 32'h1000_0000,
  parameter logic [XLEN-1:0]  TEST_STAT_ADDR = 32'h2000_0000,
  parameter logic [XLEN-1:0]  PASS_MAGIC     = 123456789
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [XLEN-1:0]       io_addr,
  input  logic [XLEN-1:0]       io_wdata,
  input  logic                  io_we,
  input  logic                  io_re,
  output logic [XLEN-1:0]       io_rdata,
  output logic                  io_stall,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic [NCHAN-1:0]      con_valid,
  input  logic [NCHAN-1:0]      con_ready,
  output logic [NCHAN*XLEN-1:0] con_data,
  output logic                  test_passed,
  output logic                  test_failed,
  output logic [XLEN-1:0]       fail_code
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [NCHAN-1:0] chan_hit;
  logic [NCHAN-1:0] chan_full;
  logic [NCHAN-1:0] chan_push;
  logic             test_hit;
  logic             hub_store;

`ifdef MMIO_HUB_STATUS_EN
  logic [NCHAN-1:0] stat_hit;
  logic [XLEN-1:0]  chan_free [NCHAN];
`endif

  for (genvar n = 0; n < NCHAN; n++) begin : g_chan
    localparam logic [XLEN-1:0] CH_ADDR = CONSOLE_BASE + XLEN'(16 * n);

    logic [XLEN-1:0] mem [FIFO_DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]     wr_ptr;
    logic [PW:0]     rd_ptr;
    logic            empty;
    logic            pop;

    assign chan_hit[n]  = (io_addr == CH_ADDR);
    assign empty        = (wr_ptr == rd_ptr);
    // Full looks only at registered pointers: a pop this cycle cannot
    // release a stalled store until the next cycle.
    assign chan_full[n] = (wr_ptr[PW] != rd_ptr[PW]) &&
                          (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign chan_push[n] = reset_n && io_we && chan_hit[n] && !chan_full[n];
    assign pop          = !empty && con_ready[n];

    assign con_valid[n]                = !empty;
    assign con_data[n*XLEN +: XLEN]    = mem[rd_ptr[PW-1:0]];

`ifdef MMIO_HUB_STATUS_EN
    logic [PW:0] used;
    assign used         = wr_ptr - rd_ptr;
    assign stat_hit[n]  = (io_addr == CH_ADDR + XLEN'(4));
    assign chan_free[n] = XLEN'((PW+1)'(FIFO_DEPTH) - used);
`endif

    // Storage needs no reset: contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
      if (chan_push[n]) mem[wr_ptr[PW-1:0]] <= io_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (chan_push[n]) wr_ptr <= wr_ptr + 1'b1;
        if (pop)          rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign test_hit  = (io_addr == TEST_STAT_ADDR);
  assign hub_store = (|chan_hit) || test_hit;

  // Gated by reset_n so a store held across reset is dropped immediately.
  assign io_stall   = reset_n && io_we && |(chan_hit & chan_full);
  assign dmem_we    = reset_n && io_we && !hub_store;
  assign dmem_wdata = io_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      test_passed <= 1'b0;
      test_failed <= 1'b0;
      fail_code   <= '0;
    end else if (io_we && test_hit) begin
      if (io_wdata == PASS_MAGIC) begin
        test_passed <= 1'b1;
      end else if (!test_failed) begin
        // Only the first failure code is kept.
        test_failed <= 1'b1;
        fail_code   <= io_wdata;
      end
    end
  end

  always_comb begin
    io_rdata = dmem_rdata;
    if (io_re) begin
      if (hub_store) io_rdata = '0;
`ifdef MMIO_HUB_STATUS_EN
      for (int n = 0; n < NCHAN; n++) begin
        if (stat_hit[n]) io_rdata = chan_free[n];
      end
      if (io_addr == TEST_STAT_ADDR + XLEN'(4)) begin
        io_rdata = {{(XLEN-2){1'b0}}, test_failed, test_passed};
      end
`endif
    end
  end

endmodule

// File: doc/mmio_hub.md
MMIO_HUB -- requirements
Module: mmio_hub

Interface
REQ-001 Parameter XLEN, default 32, data/address width.
REQ-002 Parameter NCHAN, default 2, number of console output channels (1..4).
REQ-003 Parameter FIFO_DEPTH, default 8, entries per channel FIFO (power of two, 2..16).
REQ-004 Parameter CONSOLE_BASE, default 32'h1000_0000, channel 0 data address; channel n at CONSOLE_BASE + 16*n.
REQ-005 Parameter TEST_STAT_ADDR, default 32'h2000_0000, test status address.
REQ-006 Parameter PASS_MAGIC, default 123456789, value marking test pass.
REQ-007 clk  input  1  single clock; all state on rising edge.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 io_addr / io_wdata  input  XLEN each  address and store data from datapath.
REQ-010 io_we / io_re  input  1 each  store / load strobe from datapath.
REQ-011 io_rdata  output  XLEN  load data to datapath.
REQ-012 io_stall  output  1  datapath must hold the current store.
REQ-013 dmem_we / dmem_wdata  output  1 / XLEN  filtered write to data memory.
REQ-014 dmem_rdata  input  XLEN  data memory read data.
REQ-015 con_valid / con_ready  output / input  NCHAN each  per-channel stream handshake.
REQ-016 con_data  output  NCHAN*XLEN  channel n data in bits [n*XLEN +: XLEN].
REQ-017 test_passed / test_failed  output  1 each  sticky test result flags.
REQ-018 fail_code  output  XLEN  first non-magic value written to TEST_STAT_ADDR.

Function
REQ-019 Store to channel n data address (n < NCHAN) SHALL push io_wdata into FIFO n at clock edge when FIFO n not full; dmem_we=0.
REQ-020 Store to full FIFO n SHALL drive io_stall=1 combinationally, no push, no dmem write; push completes on first cycle FIFO not full.
REQ-021 Full SHALL be evaluated on registered state only; a pop in the same cycle does not clear stall for that cycle.
REQ-022 con_valid[n] SHALL equal FIFO n non-empty; con_data SHALL show head entry; pop on con_valid && con_ready at edge.
REQ-023 Push and pop on the same non-empty, non-full FIFO SHALL both occur; occupancy unchanged.
REQ-024 Push to empty FIFO SHALL make con_valid high the next cycle (latency 1); FIFO order preserved; pointers wrap modulo FIFO_DEPTH with extra wrap bit for full/empty.
REQ-025 Store to TEST_STAT_ADDR with PASS_MAGIC SHALL set test_passed; any other value SHALL set test_failed and latch fail_code, only if test_failed was 0; no dmem write.
REQ-026 test_passed and test_failed SHALL be independently sticky until reset.
REQ-027 All other stores SHALL pass through: dmem_we=io_we, dmem_wdata=io_wdata, combinational, io_stall=0.
REQ-028 Loads from unmapped-to-hub addresses SHALL return dmem_rdata; loads from channel data address SHALL return 0 and not pop.
REQ-029 Addresses CONSOLE_BASE+16*n for n >= NCHAN SHALL be treated as ordinary memory.

Reset
REQ-030 reset_n low SHALL immediately clear all FIFO pointers, con_valid, test_passed, test_failed, fail_code to 0, and force io_stall=0 and dmem_we=0.
REQ-031 Reset asserted mid-operation SHALL discard FIFO contents; a stalled store is dropped.

Configuration
REQ-032 Macro MMIO_HUB_STATUS_EN defined: load from CONSOLE_BASE+16*n+4 SHALL return {free-entry count in low bits, zero-extended}; load from TEST_STAT_ADDR+4 SHALL return {XLEN-2 zeros, test_failed, test_passed}.
REQ-033 Macro undefined: those addresses SHALL behave as ordinary memory (REQ-027/028).

Verification
REQ-034 Store 0x41 to 0x1000_0000, con_ready[0]=1 -> con_valid[0] high one cycle later with con_data=0x41, then low.
REQ-035 FIFO_DEPTH=8, con_ready=0, 9 stores to channel 1 -> first 8 accepted, 9th holds io_stall=1 until con_ready[1] pulses once; 9 values exit in order.
REQ-036 Store 7 then 123456789 to 0x2000_0000 -> test_failed=1, fail_code=7, test_passed=1; later store 9 leaves fail_code=7.
REQ-037 Store 0xDEAD to 0x0000_0100 -> dmem_we=1, dmem_wdata=0xDEAD same cycle; no con_valid change.
REQ-038 Fill channel 0 with 3 entries, pulse reset_n low mid-cycle -> con_valid[0]=0 and flags 0 immediately, without clock edge.
REQ-039 With MMIO_HUB_STATUS_EN, 3 entries in channel 0 depth 8 -> load 0x1000_0004 returns 5; without macro returns dmem_rdata.
